// File: rtl/reg_file_param.sv
// reg_file_param: multi-read-port register file with per-register pending scoreboard
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   rd_en     per-port read request (NRD)
//   rd_addr   read addresses, port i at [i*AW +: AW]
//   rd_data   registered read data, port i at [i*XLEN +: XLEN]
//   rd_busy   registered pending bit of the addressed register, per port
//   wr_en     writeback strobe, clears pending of wr_addr
//   wr_addr   writeback address
//   wr_data   writeback data
//   iss_en    issue strobe, sets pending of iss_addr
//   iss_addr  destination register of the issued instruction
module reg_file_param #(
  parameter int XLEN = 64,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pending, pendNext;
  logic [XLEN-1:0] dNext [NRD];
  logic [NRD-1:0] bNext;
  logic [AW-1:0] rdA [NRD];
  logic wrOk, issOk;
  logic [NRD-1:0] hit;
  // Out-of-range addresses and a hardwired zero register behave as absent storage.
  function automatic logic usable(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREGS)) && (ZERO_REG == 0 || a != '0);
  endfunction
  always_comb begin
    wrOk = wr_en && usable(wr_addr);
    issOk = iss_en && usable(iss_addr);
    hit = '0;
    bNext = '0;
    // Issue wins over writeback on the same register in the same cycle.
    for (int r = 0; r < NREGS; r++)
      pendNext[r] = (issOk && iss_addr == AW'(r)) ? 1'b1 : (wrOk && wr_addr == AW'(r)) ? 1'b0 : pending[r];
    for (int i = 0; i < NRD; i++) begin
      rdA[i] = rd_addr[i*AW +: AW];
      hit[i] = (BYPASS != 0) && wrOk && wr_addr == rdA[i];
      dNext[i] = !usable(rdA[i]) ? '0 : hit[i] ? wr_data : regs[rdA[i]];
      bNext[i] = !usable(rdA[i]) ? 1'b0 : hit[i] ? (issOk && iss_addr == rdA[i]) : pending[rdA[i]];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      pending <= '0;
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      if (wrOk) regs[wr_addr] <= wr_data;
      pending <= pendNext;
      for (int i = 0; i < NRD; i++)
        if (rd_en[i]) begin
          rd_data[i*XLEN +: XLEN] <= dNext[i];
          rd_busy[i] <= bNext[i];
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed bench for reg_file_param, bypass/zero-reg instance and a plain instance side by side
module tb_reg_file_param;
  logic clk = 0, rst_n = 0;
  logic [1:0] rdEn = '0;
  logic [9:0] rdAddr = '0;
  logic wrEn = 0, issEn = 0;
  logic [4:0] wrAddr = '0, issAddr = '0;
  logic [63:0] wrData = '0;
  logic [127:0] rdData0, rdData1;
  logic [1:0] rdBusy0, rdBusy1;
  int nChecks = 0, nPass = 0;

  always #5 clk = ~clk;

  reg_file_param dut0 (.clk(clk), .rst_n(rst_n), .rd_en(rdEn), .rd_addr(rdAddr), .rd_data(rdData0),
    .rd_busy(rdBusy0), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .iss_en(issEn), .iss_addr(issAddr));
  reg_file_param #(.ZERO_REG(0), .BYPASS(0)) dut1 (.clk(clk), .rst_n(rst_n), .rd_en(rdEn), .rd_addr(rdAddr),
    .rd_data(rdData1), .rd_busy(rdBusy1), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .iss_en(issEn),
    .iss_addr(issAddr));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rdEn = '0; wrEn = 0; issEn = 0;
  endtask

  task automatic setRd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    rdEn = en; rdAddr = {a1, a0};
  endtask

  task automatic setWr(input logic en, input logic [4:0] a, input logic [63:0] d);
    wrEn = en; wrAddr = a; wrData = d;
  endtask

  initial begin
    #3;
    check("rst data0", rdData0[63:0], 0);
    check("rst busy0", 64'(rdBusy0), 0);
    check("rst data1", rdData1[127:64], 0);
    @(negedge clk);
    rst_n = 1;
    setRd(2'b11, 5, 31);
    tick;
    check("rd5 p0", rdData0[63:0], 0);
    check("rd31 p1", rdData0[127:64], 0);
    check("rd busy", 64'(rdBusy0), 0);
    idle;
    setWr(1, 7, 64'hDEAD_BEEF_0123_4567);
    tick;
    wrEn = 0;
    setRd(2'b10, 0, 7);
    tick;
    check("rd7 p1", rdData0[127:64], 64'hDEAD_BEEF_0123_4567);
    check("rd7 p1 plain", rdData1[127:64], 64'hDEAD_BEEF_0123_4567);
    setRd(2'b00, 0, 5);
    tick;
    check("hold p1", rdData0[127:64], 64'hDEAD_BEEF_0123_4567);
    setWr(1, 9, 64'h55);
    setRd(2'b01, 9, 5);
    tick;
    check("bypass", rdData0[63:0], 64'h55);
    check("nobypass", rdData1[63:0], 0);
    wrEn = 0;
    tick;
    check("rd9 after", rdData1[63:0], 64'h55);
    idle;
    issEn = 1; issAddr = 3;
    tick;
    issEn = 0;
    setRd(2'b01, 3, 5);
    tick;
    check("busy3", 64'(rdBusy0[0]), 1);
    check("busy3 plain", 64'(rdBusy1[0]), 1);
    setWr(1, 3, 64'h10);
    tick;
    check("wr3 byp data", rdData0[63:0], 64'h10);
    check("wr3 byp busy", 64'(rdBusy0[0]), 0);
    check("wr3 old data", rdData1[63:0], 0);
    check("wr3 old busy", 64'(rdBusy1[0]), 1);
    wrEn = 0;
    tick;
    check("rd3 data", rdData1[63:0], 64'h10);
    check("rd3 busy", 64'(rdBusy1[0]), 0);
    setWr(1, 3, 64'h20);
    issEn = 1; issAddr = 3;
    tick;
    check("iss+wr byp data", rdData0[63:0], 64'h20);
    check("iss+wr byp busy", 64'(rdBusy0[0]), 1);
    check("iss+wr old busy", 64'(rdBusy1[0]), 0);
    idle;
    rdEn = 2'b01;
    tick;
    check("iss+wr data", rdData1[63:0], 64'h20);
    check("iss+wr busy", 64'(rdBusy1[0]), 1);
    idle;
    setWr(1, 0, 64'hFFFF);
    issEn = 1; issAddr = 0;
    tick;
    idle;
    setRd(2'b11, 0, 0);
    tick;
    check("r0 data", rdData0[63:0], 0);
    check("r0 busy", 64'(rdBusy0), 0);
    check("r0 plain data", rdData1[127:64], 64'hFFFF);
    check("r0 plain busy", 64'(rdBusy1), 3);
    idle;
    setWr(1, 4, 64'hAB);
    issEn = 1; issAddr = 12;
    tick;
    idle;
    setRd(2'b11, 4, 12);
    tick;
    check("pre rst data", rdData0[63:0], 64'hAB);
    check("pre rst busy", 64'(rdBusy0), 2);
    setWr(1, 4, 64'hCD);
    issEn = 1; issAddr = 12;
    #2 rst_n = 0;
    #1;
    check("async data", rdData0[63:0], 0);
    check("async busy", 64'(rdBusy0), 0);
    idle;
    @(negedge clk);
    rst_n = 1;
    setRd(2'b11, 4, 12);
    tick;
    check("post rst r4", rdData0[63:0], 0);
    check("post rst busy", 64'(rdBusy0), 0);
    check("post rst plain", rdData1[63:0], 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
